serial_tx: RTL

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/serial_tx.sv
// LSB-first parallel-to-serial transmitter with a valid/ready load port and a forced inter-frame gap.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit after the data bits.
module serial_tx #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data_out,
  output logic             shift_en,
  output logic             busy,
  output logic             frame_done
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]     GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam bit             HAS_GAP  = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    GAP    = 2'd2
`ifdef SERIAL_TX_PARITY_EN
    ,PARITY = 2'd3
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             data_out_q, data_out_d;
  logic             shift_en_q, shift_en_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             load_ready_q, load_ready_d;
`ifdef SERIAL_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gcnt_d       = gcnt_q;
    sh_d         = sh_q;
    data_out_d   = 1'b0;
    shift_en_d   = 1'b0;
    frame_done_d = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_valid && load_ready_q) begin
          // bit 0 goes straight to the output register; the word keeps the remaining bits
          state_d    = SHIFT;
          cnt_d      = '0;
          sh_d       = {1'b0, data_in[WIDTH-1:1]};
          data_out_d = data_in[0];
          shift_en_d = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
          par_d      = ^data_in;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
          state_d      = PARITY;
          data_out_d   = par_q;
          shift_en_d   = 1'b1;
`else
          frame_done_d = 1'b1;
          state_d      = HAS_GAP ? GAP : IDLE;
          gcnt_d       = '0;
`endif
        end else begin
          cnt_d      = cnt_q + 1'b1;
          data_out_d = sh_q[0];
          sh_d       = {1'b0, sh_q[WIDTH-1:1]};
          shift_en_d = 1'b1;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        frame_done_d = 1'b1;
        state_d      = HAS_GAP ? GAP : IDLE;
        gcnt_d       = '0;
      end
`endif
      GAP: begin
        if (gcnt_q == GAP_LAST) state_d = IDLE;
        else                    gcnt_d  = gcnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    load_ready_d = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      gcnt_q       <= '0;
      sh_q         <= '0;
      data_out_q   <= 1'b0;
      shift_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      load_ready_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gcnt_q       <= gcnt_d;
      sh_q         <= sh_d;
      data_out_q   <= data_out_d;
      shift_en_q   <= shift_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      load_ready_q <= load_ready_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign load_ready = load_ready_q;
  assign data_out   = data_out_q;
  assign shift_en   = shift_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
